// File: rtl/sdram_port_arbiter_pkg.sv
// sdram_port_arbiter_pkg: shared state encoding, default widths and round-robin index helper
package sdram_port_arbiter_pkg;
  localparam int DEF_ADDR_W = 23;
  localparam int DEF_DATA_W = 8;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;
  function automatic int rot_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction
endpackage

// File: rtl/sdram_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first request after ptr wins
module rr_pick
  import sdram_port_arbiter_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          valid
);
  always_comb begin
    grant = '0;
    idx   = '0;
    // walk offsets from far to near so the nearest requester after ptr overrides
    for (int i = N; i >= 1; i--) begin
      if (i_req[rot_idx(int'(ptr), i, N)]) begin
        grant = '0;
        grant[rot_idx(int'(ptr), i, N)] = 1'b1;
        idx = PW'(rot_idx(int'(ptr), i, N));
      end
    end
  end
  assign valid = |i_req;
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin sharing of one SDRAM controller port among N_REQ requesters
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ-1:0]         i_wren,
  input  logic [N_REQ*ADDR_W-1:0]  i_addr,
  input  logic [N_REQ*DATA_W-1:0]  i_wdata,
  output logic [N_REQ-1:0]         o_ack,
  output logic                     o_err,
  output logic [DATA_W-1:0]        o_rdata,
  output logic [N_REQ-1:0]         o_grant,
  output logic                     o_busy,
  output logic                     o_mem_request,
  output logic                     o_mem_wren,
  output logic [ADDR_W-1:0]        o_mem_address,
  output logic [DATA_W-1:0]        o_mem_data,
  input  logic [DATA_W-1:0]        i_mem_data,
  input  logic                     i_mem_done
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state, nxt;
  logic [PW-1:0]   ptr, gidx, pick_idx;
  logic [N_REQ-1:0] pick;
  logic            pick_v, tmo, err;
  logic [CW-1:0]   cnt;

  rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .i_req (i_req),
    .ptr   (ptr),
    .grant (pick),
    .idx   (pick_idx),
    .valid (pick_v)
  );

  // counter is compared before increment, so the wait lasts exactly TIMEOUT cycles
  assign tmo = cnt == CW'(TIMEOUT - 1);

  always_comb begin
    nxt = state == S_IDLE  ? (pick_v ? S_ISSUE : S_IDLE) :
          state == S_ISSUE ? S_WAIT :
          state == S_WAIT  ? ((i_mem_done || tmo) ? S_RESP : S_WAIT) : S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else state <= nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr           <= PW'(N_REQ - 1);
      gidx          <= '0;
      cnt           <= '0;
      err           <= 1'b0;
      o_grant       <= '0;
      o_rdata       <= '0;
      o_mem_wren    <= 1'b0;
      o_mem_address <= '0;
      o_mem_data    <= '0;
    end else if (state == S_IDLE) begin
      if (pick_v) begin
        o_grant       <= pick;
        gidx          <= pick_idx;
        o_mem_wren    <= i_wren[pick_idx];
        o_mem_address <= i_addr[pick_idx*ADDR_W +: ADDR_W];
        o_mem_data    <= i_wdata[pick_idx*DATA_W +: DATA_W];
      end
    end else if (state == S_ISSUE) begin
      cnt <= '0;
    end else if (state == S_WAIT) begin
      if (i_mem_done) begin
        err <= 1'b0;
        if (!o_mem_wren) o_rdata <= i_mem_data;
      end else begin
        cnt <= cnt + CW'(1);
        if (tmo) err <= 1'b1;
      end
    end else begin
      ptr     <= gidx;
      o_grant <= '0;
    end
  end

  assign o_mem_request = state == S_ISSUE;
  assign o_busy        = state != S_IDLE;
  assign o_ack         = state == S_RESP ? o_grant : '0;
  assign o_err         = state == S_RESP && err;
endmodule
